// File: rtl/pacote_processador.sv
// Shared processor definitions: loader FSM encoding,
// instruction-memory geometry defaults and opcodes.
package pacote_processador;

  typedef enum logic [2:0] {
    OCIOSO   = 3'd0,
    CONTAGEM = 3'd1,
    DADOS    = 3'd2,
    ESCREVE  = 3'd3,
    VERIFICA = 3'd4,
    FIM      = 3'd5
  } estado_carga_t;

  localparam int TAM_MEMORIA_PADRAO      = 141;
  localparam int ENDERECO_INICIAL_PADRAO = 1;

  localparam logic [4:0] OP_NOP   = 5'b00000;
  localparam logic [4:0] OP_LOAD  = 5'b00001;
  localparam logic [4:0] OP_STORE = 5'b00010;
  localparam logic [4:0] OP_ADD   = 5'b00011;
  localparam logic [4:0] OP_SUB   = 5'b00100;
  localparam logic [4:0] OP_AND   = 5'b00101;
  localparam logic [4:0] OP_OR    = 5'b00110;
  localparam logic [4:0] OP_JUMP  = 5'b00111;
  localparam logic [4:0] OP_BEQ   = 5'b01000;
  localparam logic [4:0] OP_HALT  = 5'b11111;

endpackage

// File: rtl/carregador_programa.sv
// Serial program loader: count, big-endian words into
// instruction memory, trailing XOR checksum byte.
module carregador_programa
  import pacote_processador::*;
#(
  parameter int TAM_MEMORIA      = TAM_MEMORIA_PADRAO,
  parameter int ENDERECO_INICIAL = ENDERECO_INICIAL_PADRAO
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        inicio,
  input  logic [7:0]  byte_entrada,
  input  logic        byte_valido,
  output logic        byte_pronto,
  output logic        escrita,
  output logic [31:0] endereco_escrita,
  output logic [31:0] dado_escrita,
  output logic        ocupado,
  output logic        concluido,
  output logic        erro
);

  localparam logic [31:0] LIMITE =
    32'(TAM_MEMORIA - ENDERECO_INICIAL);
  localparam logic [31:0] BASE = 32'(ENDERECO_INICIAL);

  estado_carga_t estado_q;
  logic [15:0]   n_q;
  logic [15:0]   k_q;
  logic [1:0]    idx_q;
  logic [31:0]   asm_q;
  logic [7:0]    chk_q;
  logic          escrita_q;
  logic [31:0]   end_q;
  logic [31:0]   dado_q;
  logic          concluido_q;
  logic          erro_q;

  logic          aceita;
  logic [15:0]   n_d;
  logic [31:0]   asm_d;
  logic [7:0]    chk_d;

  assign byte_pronto = (estado_q == CONTAGEM) ||
                       (estado_q == DADOS) ||
                       (estado_q == VERIFICA);
  assign ocupado     = byte_pronto || (estado_q == ESCREVE);
  assign aceita      = byte_valido && byte_pronto;
  assign n_d         = {n_q[15:8], byte_entrada};
  assign asm_d       = {asm_q[23:0], byte_entrada};
  assign chk_d       = chk_q ^ byte_entrada;

  assign escrita          = escrita_q;
  assign endereco_escrita = end_q;
  assign dado_escrita     = dado_q;
  assign concluido        = concluido_q;
  assign erro             = erro_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q    <= OCIOSO;
      n_q         <= '0;
      k_q         <= '0;
      idx_q       <= '0;
      asm_q       <= '0;
      chk_q       <= '0;
      escrita_q   <= 1'b0;
      end_q       <= '0;
      dado_q      <= '0;
      concluido_q <= 1'b0;
      erro_q      <= 1'b0;
    end else begin
      unique case (estado_q)
        OCIOSO, FIM: begin
          if (inicio) begin
            estado_q    <= CONTAGEM;
            n_q         <= '0;
            k_q         <= '0;
            idx_q       <= '0;
            asm_q       <= '0;
            chk_q       <= '0;
            concluido_q <= 1'b0;
            erro_q      <= 1'b0;
          end
        end
        CONTAGEM: begin
          if (aceita) begin
            chk_q <= chk_d;
            if (idx_q == 2'd0) begin
              n_q   <= {byte_entrada, 8'h00};
              idx_q <= 2'd1;
            end else begin
              n_q   <= n_d;
              idx_q <= 2'd0;
              if (n_d == 16'd0) begin
                estado_q <= VERIFICA;
              end else if ({16'h0, n_d} > LIMITE) begin
                estado_q    <= FIM;
                erro_q      <= 1'b1;
                concluido_q <= 1'b1;
              end else begin
                estado_q <= DADOS;
              end
            end
          end
        end
        DADOS: begin
          if (aceita) begin
            chk_q <= chk_d;
            asm_q <= asm_d;
            idx_q <= idx_q + 2'd1;
            if (idx_q == 2'd3) begin
              estado_q  <= ESCREVE;
              escrita_q <= 1'b1;
              dado_q    <= asm_d;
              end_q     <= BASE + {16'h0, k_q};
              k_q       <= k_q + 16'd1;
            end
          end
        end
        ESCREVE: begin
          escrita_q <= 1'b0;
          estado_q  <= (k_q == n_q) ? VERIFICA : DADOS;
        end
        VERIFICA: begin
          if (aceita) begin
            chk_q       <= chk_d;
            erro_q      <= (byte_entrada != chk_q);
            concluido_q <= 1'b1;
            estado_q    <= FIM;
          end
        end
        default: estado_q <= OCIOSO;
      endcase
    end
  end

endmodule

// File: tb/tb_carregador_programa.sv
// Directed self-checking bench for the program loader.
module tb_carregador_programa;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        inicio = 1'b0;
  logic [7:0]  byte_entrada = 8'h00;
  logic        byte_valido = 1'b0;
  logic        byte_pronto;
  logic        escrita;
  logic [31:0] endereco_escrita;
  logic [31:0] dado_escrita;
  logic        ocupado;
  logic        concluido;
  logic        erro;

  int tests = 0;
  int fails = 0;

  typedef logic [7:0] stream_t [16];

  int          n_wr = 0;
  logic [31:0] wr_addr [8];
  logic [31:0] wr_data [8];
  int          bad_wr = 0;
  int          dbl_wr = 0;
  logic        acc_q = 1'b0;
  logic        esc_prev = 1'b0;

  carregador_programa dut (
    .clock            (clock),
    .reset            (reset),
    .inicio           (inicio),
    .byte_entrada     (byte_entrada),
    .byte_valido      (byte_valido),
    .byte_pronto      (byte_pronto),
    .escrita          (escrita),
    .endereco_escrita (endereco_escrita),
    .dado_escrita     (dado_escrita),
    .ocupado          (ocupado),
    .concluido        (concluido),
    .erro             (erro)
  );

  always #5 clock = ~clock;

  always @(posedge clock)
    acc_q <= byte_valido && byte_pronto && !reset;

  always @(negedge clock) begin
    if (escrita) begin
      if (n_wr < 8) begin
        wr_addr[n_wr] = endereco_escrita;
        wr_data[n_wr] = dado_escrita;
      end
      n_wr = n_wr + 1;
      if (!acc_q) bad_wr = bad_wr + 1;
      if (esc_prev) dbl_wr = dbl_wr + 1;
    end
    esc_prev = escrita;
  end

  task automatic chk32(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    @(posedge clock);
    #1;
    n_wr   = 0;
    bad_wr = 0;
    dbl_wr = 0;
  endtask

  task automatic start_load();
    @(negedge clock);
    inicio = 1'b1;
    @(negedge clock);
    inicio = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input bit gap);
    bit done;
    done = 0;
    if (gap) begin
      byte_valido = 1'b0;
      @(negedge clock);
    end
    byte_valido  = 1'b1;
    byte_entrada = b;
    for (int i = 0; i < 20 && !done; i++) begin
      if (byte_pronto) done = 1;
      @(negedge clock);
    end
    byte_valido = 1'b0;
    tests++;
    assert (done) else begin
      fails++;
      $error("FAIL send_timeout: byte %h not accepted", b);
    end
  endtask

  task automatic send_stream(input stream_t s, input int n,
                             input bit gap);
    for (int i = 0; i < n; i++) send(s[i], gap);
  endtask

  task automatic check_good(input string tag, input logic e);
    chk32({tag, "_nwr"}, 32'(n_wr), 32'd2);
    chk32({tag, "_a0"}, wr_addr[0], 32'd1);
    chk32({tag, "_d0"}, wr_data[0], 32'hC840_0000);
    chk32({tag, "_a1"}, wr_addr[1], 32'd2);
    chk32({tag, "_d1"}, wr_data[1], 32'hC040_0005);
    chk32({tag, "_lat"}, 32'(bad_wr), 32'd0);
    chk32({tag, "_pulse"}, 32'(dbl_wr), 32'd0);
    chk32({tag, "_conc"}, {31'h0, concluido}, 32'd1);
    chk32({tag, "_erro"}, {31'h0, erro}, {31'h0, e});
    chk32({tag, "_ocup"}, {31'h0, ocupado}, 32'd0);
    chk32({tag, "_rdy"}, {31'h0, byte_pronto}, 32'd0);
  endtask

  stream_t good;
  stream_t bad;
  stream_t big;
  stream_t zero;

  initial begin
    good = '{8'h00, 8'h02, 8'hC8, 8'h40, 8'h00, 8'h00,
             8'hC0, 8'h40, 8'h00, 8'h05, 8'h0F,
             8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    bad = good;
    bad[10] = 8'h0E;
    big  = '{default: 8'h00};
    big[1] = 8'h8D;
    zero = '{default: 8'h00};

    // reset state, with inicio also high
    inicio = 1'b1;
    repeat (2) @(negedge clock);
    chk32("rst_esc", {31'h0, escrita}, 32'd0);
    chk32("rst_rdy", {31'h0, byte_pronto}, 32'd0);
    chk32("rst_ocup", {31'h0, ocupado}, 32'd0);
    chk32("rst_conc", {31'h0, concluido}, 32'd0);
    chk32("rst_erro", {31'h0, erro}, 32'd0);
    chk32("rst_addr", endereco_escrita, 32'd0);
    chk32("rst_data", dado_escrita, 32'd0);
    inicio = 1'b0;
    reset  = 1'b0;
    repeat (2) @(negedge clock);
    chk32("idle_ocup", {31'h0, ocupado}, 32'd0);

    // nominal load
    clear_log();
    start_load();
    chk32("cnt_ocup", {31'h0, ocupado}, 32'd1);
    chk32("cnt_rdy", {31'h0, byte_pronto}, 32'd1);
    send_stream(good, 11, 0);
    check_good("good", 1'b0);

    // checksum mismatch
    clear_log();
    start_load();
    chk32("restart_conc", {31'h0, concluido}, 32'd0);
    send_stream(bad, 11, 0);
    check_good("bad", 1'b1);

    // oversized count
    clear_log();
    start_load();
    send_stream(big, 2, 0);
    chk32("big_rdy", {31'h0, byte_pronto}, 32'd0);
    chk32("big_erro", {31'h0, erro}, 32'd1);
    chk32("big_conc", {31'h0, concluido}, 32'd1);
    chk32("big_ocup", {31'h0, ocupado}, 32'd0);
    byte_valido = 1'b1;
    repeat (4) @(negedge clock);
    byte_valido = 1'b0;
    chk32("big_rdy2", {31'h0, byte_pronto}, 32'd0);
    chk32("big_nwr", 32'(n_wr), 32'd0);

    // empty program
    clear_log();
    start_load();
    chk32("zero_erro0", {31'h0, erro}, 32'd0);
    send_stream(zero, 3, 0);
    chk32("zero_nwr", 32'(n_wr), 32'd0);
    chk32("zero_conc", {31'h0, concluido}, 32'd1);
    chk32("zero_erro", {31'h0, erro}, 32'd0);

    // stalled stream, with a stray inicio mid-load
    clear_log();
    start_load();
    send_stream(good, 5, 1);
    inicio = 1'b1;
    @(negedge clock);
    inicio = 1'b0;
    chk32("stall_ocup", {31'h0, ocupado}, 32'd1);
    for (int i = 5; i < 11; i++) send(good[i], 1);
    check_good("stall", 1'b0);

    // reset mid-load
    start_load();
    send_stream(good, 6, 0);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk32("abort_ocup", {31'h0, ocupado}, 32'd0);
    chk32("abort_esc", {31'h0, escrita}, 32'd0);
    chk32("abort_conc", {31'h0, concluido}, 32'd0);
    clear_log();
    repeat (6) @(negedge clock);
    chk32("abort_nwr", 32'(n_wr), 32'd0);
    clear_log();
    start_load();
    send_stream(good, 11, 0);
    check_good("reload", 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/carregador_programa.md
CARREGADOR_PROGRAMA -- requirements
Module: carregador_programa

Interface
REQ-001 SHALL have parameter TAM_MEMORIA, default 141: number of instruction-memory words (valid indices 0..140).
REQ-002 SHALL have parameter ENDERECO_INICIAL, default 1: index of the first word written (program entry).
REQ-003 SHALL have port clock  input  1: sole clock; all state changes on posedge.
REQ-004 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-005 SHALL have port inicio  input  1: one-cycle start-of-load request.
REQ-006 SHALL have port byte_entrada  input  8: serial program byte.
REQ-007 SHALL have port byte_valido  input  1: byte_entrada holds a byte.
REQ-008 SHALL have port byte_pronto  output  1: loader accepts a byte this cycle.
REQ-009 SHALL have port escrita  output  1: instruction-memory write strobe.
REQ-010 SHALL have port endereco_escrita  output  32: write word index (upper bits zero).
REQ-011 SHALL have port dado_escrita  output  32: instruction word to write.
REQ-012 SHALL have port ocupado, concluido and erro  output  1 each: load status; processor held while ocupado=1.

Function
REQ-013 SHALL transfer a byte only in a cycle with byte_valido=1 and byte_pronto=1.
REQ-014 SHALL implement states OCIOSO, CONTAGEM, DADOS, ESCREVE, VERIFICA, FIM.
REQ-015 OCIOSO: byte_pronto=0, ocupado=0; inicio=1 -> CONTAGEM next cycle, clearing concluido, erro, checksum, counters.
REQ-016 CONTAGEM: byte_pronto=1; accept 2 bytes as word count N, big-endian 16 bits.
REQ-017 After the count: N=0 -> VERIFICA; N > TAM_MEMORIA-ENDERECO_INICIAL (140) -> FIM with erro=1, no writes, no further bytes consumed; otherwise -> DADOS.
REQ-018 DADOS: byte_pronto=1; assemble 4 bytes big-endian (first byte -> bits 31:24); 4th accepted byte -> ESCREVE.
REQ-019 ESCREVE: exactly one cycle, escrita=1, byte_pronto=0, dado_escrita=assembled word, endereco_escrita=ENDERECO_INICIAL+k for word k (0-based); then DADOS, or VERIFICA after word N.
REQ-020 Write latency: escrita asserts the cycle after the 4th byte of a word is accepted.
REQ-021 Checksum SHALL be the 8-bit XOR of every accepted byte, count bytes included.
REQ-022 VERIFICA: byte_pronto=1; accept 1 byte; mismatch with running checksum -> erro=1; then FIM.
REQ-023 FIM: ocupado=0, concluido=1, byte_pronto=0; erro and concluido held until next inicio; inicio=1 -> CONTAGEM.
REQ-024 ocupado SHALL be 1 in CONTAGEM, DADOS, ESCREVE, VERIFICA.
REQ-025 inicio while ocupado=1 SHALL be ignored.
REQ-026 byte_valido gaps SHALL stall without state or checksum change.
REQ-027 escrita SHALL never assert outside ESCREVE; dado_escrita/endereco_escrita are don't-care when escrita=0.

Reset
REQ-028 reset=1 at any posedge SHALL force OCIOSO, zero counters/checksum/assembly register, and drive escrita, byte_pronto, ocupado, concluido, erro, endereco_escrita, dado_escrita to 0.
REQ-029 Reset mid-load SHALL abandon the load with no further write; words already written remain.
REQ-030 reset SHALL take priority over inicio in the same cycle.

Structure
REQ-031 SHALL place state encoding and TAM_MEMORIA/ENDERECO_INICIAL defaults in shared package pacote_processador, alongside the 5-bit opcode constants.
REQ-032 SHALL be a single module; no sub-module required.

Verification
REQ-033 Bytes 00 02 C8 40 00 00 C0 40 00 05 0F, valid every cycle -> writes [1]=C8400000, [2]=C0400005, escrita one cycle each, concluido=1, erro=0.
REQ-034 Same stream, last byte 0E -> both writes occur, concluido=1, erro=1.
REQ-035 Bytes 00 8D (N=141) -> FIM with erro=1, zero writes, byte_pronto=0 after second byte.
REQ-036 Bytes 00 00 00 (N=0, checksum 00) -> no writes, concluido=1, erro=0.
REQ-037 REQ-033 stream with byte_valido toggling every other cycle -> identical writes and status; no escrita during stalls.
REQ-038 reset pulsed after 6th byte, then REQ-033 stream -> no write during abort, then writes [1], [2] correctly.
